// File: rtl/adder_pkg.sv
// Shared definitions for the adder bring-up checker: default widths, FSM
// state encoding and the error-count saturation value.
package adder_pkg;

  localparam int DEF_OP_W    = 4;
  localparam int DEF_SUM_W   = 8;
  localparam int DEF_ADD_LAT = 1;

  localparam logic [7:0] ERR_SAT = 8'd255;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/adder_exp_pipe.sv
// Delay line that carries {valid, payload} alongside the adder so that each
// expected value arrives at the checker in the same cycle as its sum.
module adder_exp_pipe #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o
);

  logic [DEPTH-1:0] valid_q;
  logic [W-1:0]     data_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid_i;
      data_q[0]  <= in_data_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign out_data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/adder_vec_driver.sv
// Exhaustive operand sweep for the registered adder: launches every {a,b}
// pair, compares the returned sum against a delayed expected value, and reports.
module adder_vec_driver
  import adder_pkg::*;
#(
  parameter int OP_W    = DEF_OP_W,
  parameter int SUM_W   = DEF_SUM_W,
  parameter int ADD_LAT = DEF_ADD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [OP_W-1:0]   a_out,
  output logic [OP_W-1:0]   b_out,
  input  logic [SUM_W-1:0]  c_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_cnt,
  output logic [2*OP_W-1:0] first_err_vec,
  output logic [SUM_W-1:0]  first_err_c,
  output state_e            state_dbg
);

  localparam int VEC_W = 2 * OP_W;
  localparam int PAY_W = VEC_W + SUM_W;
  localparam logic [VEC_W-1:0] LAST_VEC = '1;

  // Handshake: start is a one-cycle request honoured only in IDLE; busy marks
  // the sweep and drain; done pulses once, in the cycle pass becomes final.
  state_e            state_q;
  logic [VEC_W-1:0]  idx_q;
  logic [2:0]        drain_q;
  logic [OP_W-1:0]   a_q, b_q;
  logic              busy_q, done_q, pass_q;
  logic [7:0]        err_q, err_d;
  logic [VEC_W-1:0]  fvec_q, fvec_d;
  logic [SUM_W-1:0]  fc_q, fc_d;

  logic              push_valid;
  logic [SUM_W-1:0]  push_exp;
  logic [PAY_W-1:0]  push_data;
  logic              chk_valid;
  logic [PAY_W-1:0]  chk_data;
  logic [VEC_W-1:0]  chk_vec;
  logic [SUM_W-1:0]  chk_exp;
  logic              mismatch;

  // The entry pushed on an edge in DRIVE describes the vector launched on that edge.
  assign push_valid = (state_q == S_DRIVE);
  assign push_exp   = SUM_W'(idx_q[VEC_W-1:OP_W]) + SUM_W'(idx_q[OP_W-1:0]);
  assign push_data  = {idx_q, push_exp};

  adder_exp_pipe #(
    .W     (PAY_W),
    .DEPTH (ADD_LAT + 1)
  ) u_exp_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (push_valid),
    .in_data_i   (push_data),
    .out_valid_o (chk_valid),
    .out_data_o  (chk_data)
  );

  assign chk_vec  = chk_data[PAY_W-1:SUM_W];
  assign chk_exp  = chk_data[SUM_W-1:0];
  assign mismatch = chk_valid && (c_in != chk_exp);

  always_comb begin
    err_d  = err_q;
    fvec_d = fvec_q;
    fc_d   = fc_q;
    if (state_q == S_IDLE && start) begin
      err_d  = '0;
      fvec_d = '0;
      fc_d   = '0;
    end else if (mismatch) begin
      if (err_q != ERR_SAT) begin
        err_d = err_q + 8'd1;
      end
      if (err_q == '0) begin
        fvec_d = chk_vec;
        fc_d   = c_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      drain_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fvec_q  <= '0;
      fc_q    <= '0;
    end else begin
      err_q  <= err_d;
      fvec_q <= fvec_d;
      fc_q   <= fc_d;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_DRIVE;
            idx_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_DRIVE: begin
          a_q <= idx_q[VEC_W-1:OP_W];
          b_q <= idx_q[OP_W-1:0];
          if (idx_q == LAST_VEC) begin
            state_q <= S_DRAIN;
            drain_q <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DRAIN: begin
          // The final compare lands on the exit edge, so pass uses err_d.
          if (drain_q == 3'(ADD_LAT)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign a_out         = a_q;
  assign b_out         = b_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_q;
  assign first_err_vec = fvec_q;
  assign first_err_c   = fc_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_adder_vec_driver.sv
// Bench for adder_vec_driver: two instances (adder latency 1 and 3), each
// beside a behavioural adder with selectable faults; sweep results checked on done.
module tb_adder_vec_driver;
  import adder_pkg::*;

  localparam int EXP_W = 41;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0;
  logic start3 = 1'b0;

  always #5 clk = ~clk;

  logic [3:0] a1, b1, a3, b3;
  logic [7:0] c1, c3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [7:0] err1, fvec1, fc1, err3, fvec3, fc3;
  state_e     st1, st3;

  int fault1 = 0;
  int fault3 = 0;
  int checks = 0;
  int errors = 0;
  int done1_cnt = 0;
  int done3_cnt = 0;
  logic [EXP_W-1:0] exp1_q[$];
  logic [EXP_W-1:0] exp3_q[$];

  adder_vec_driver #(.OP_W(4), .SUM_W(8), .ADD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1), .c_in(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_err_vec(fvec1), .first_err_c(fc1), .state_dbg(st1)
  );

  adder_vec_driver #(.OP_W(4), .SUM_W(8), .ADD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a_out(a3), .b_out(b3), .c_in(c3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .first_err_vec(fvec3), .first_err_c(fc3), .state_dbg(st3)
  );

  // Adder under test: 0 golden, 1 wrong sum for 3+5, 2 stuck at zero, 3 carry lost on 15+15.
  function automatic logic [7:0] model_sum(input logic [3:0] a, input logic [3:0] b, input int mode);
    logic [7:0] s;
    s = {4'd0, a} + {4'd0, b};
    if (mode == 2) s = 8'h00;
    else if (mode == 1 && a == 4'd3 && b == 4'd5) s = 8'h09;
    else if (mode == 3 && a == 4'd15 && b == 4'd15) s = 8'h0E;
    return s;
  endfunction

  logic [7:0] s3a, s3b;
  always @(posedge clk) begin
    c1  <= model_sum(a1, b1, fault1);
    s3a <= model_sum(a3, b3, fault3);
    s3b <= s3a;
    c3  <= s3b;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] mk_exp(input logic p, input logic [7:0] e,
                                              input logic [7:0] fv, input logic [7:0] fc,
                                              input logic [15:0] blen);
    return {p, e, fv, fc, blen};
  endfunction

  task automatic check_done(input string tag, input logic [EXP_W-1:0] e, input logic p,
                            input logic [7:0] er, input logic [7:0] fv, input logic [7:0] fc,
                            input int blen, input logic vbad);
    check({tag, "_pass"},    64'(p),    64'(e[40]));
    check({tag, "_err_cnt"}, 64'(er),   64'(e[39:32]));
    check({tag, "_fvec"},    64'(fv),   64'(e[31:24]));
    check({tag, "_fc"},      64'(fc),   64'(e[23:16]));
    check({tag, "_busy_len"}, 64'(blen), 64'(e[15:0]));
    check({tag, "_vec_seq"}, 64'(vbad), 64'd0);
  endtask

  // Monitors: track busy length and the launched-vector sequence, pop on done.
  int blen1 = 0, blen3 = 0, ev1, ev3;
  logic vbad1 = 1'b0, vbad3 = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      blen1 = 0;
      vbad1 = 1'b0;
    end else begin
      if (busy1) begin
        blen1++;
        ev1 = (blen1 - 2 > 255) ? 255 : blen1 - 2;
        if (blen1 >= 2 && {a1, b1} != 8'(ev1)) vbad1 = 1'b1;
      end
      if (done1) begin
        done1_cnt++;
        if (exp1_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL d1_unexpected_done: got done with empty queue, required none");
        end else begin
          check_done("d1", exp1_q.pop_front(), pass1, err1, fvec1, fc1, blen1, vbad1);
        end
        blen1 = 0;
        vbad1 = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      blen3 = 0;
      vbad3 = 1'b0;
    end else begin
      if (busy3) begin
        blen3++;
        ev3 = (blen3 - 2 > 255) ? 255 : blen3 - 2;
        if (blen3 >= 2 && {a3, b3} != 8'(ev3)) vbad3 = 1'b1;
      end
      if (done3) begin
        done3_cnt++;
        if (exp3_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL d3_unexpected_done: got done with empty queue, required none");
        end else begin
          check_done("d3", exp3_q.pop_front(), pass3, err3, fvec3, fc3, blen3, vbad3);
        end
        blen3 = 0;
        vbad3 = 1'b0;
      end
    end
  end

  task automatic pulse_start1();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic wait_done1(input string tag);
    int n = 0;
    while (!done1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!done1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done in %0d cycles, required done", tag, n);
    end
  endtask

  task automatic wait_done3(input string tag);
    int n = 0;
    while (!done3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!done3) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done in %0d cycles, required done", tag, n);
    end
  endtask

  task automatic run1(input string tag, input logic [EXP_W-1:0] e);
    exp1_q.push_back(e);
    pulse_start1();
    wait_done1(tag);
    repeat (3) @(negedge clk);
  endtask

  task automatic run3(input string tag, input logic [EXP_W-1:0] e);
    exp3_q.push_back(e);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    wait_done3(tag);
    repeat (3) @(negedge clk);
  endtask

  int d0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy",  64'(busy1), 64'd0);
    check("rst_done",  64'(done1), 64'd0);
    check("rst_pass",  64'(pass1), 64'd0);
    check("rst_err",   64'(err1),  64'd0);
    check("rst_fvec",  64'(fvec1), 64'd0);
    check("rst_fc",    64'(fc1),   64'd0);
    check("rst_ab",    64'({a1, b1}), 64'd0);
    check("rst_state", 64'(st1),   64'(S_IDLE));
    check("rst3_busy", 64'(busy3), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Golden, single bad sum at 3+5, stuck-at-zero sum.
    fault1 = 0;
    run1("golden", mk_exp(1'b1, 8'd0, 8'h00, 8'h00, 16'd258));
    fault1 = 1;
    run1("bad35", mk_exp(1'b0, 8'd1, 8'h35, 8'h09, 16'd258));
    fault1 = 2;
    run1("stuck0", mk_exp(1'b0, 8'd255, 8'h01, 8'h00, 16'd258));
    fault1 = 0;

    // Start re-pulsed mid-sweep and in the DONE cycle must both be ignored.
    d0 = done1_cnt;
    exp1_q.push_back(mk_exp(1'b1, 8'd0, 8'h00, 8'h00, 16'd258));
    pulse_start1();
    repeat (9) @(negedge clk);
    pulse_start1();
    wait_done1("restart");
    pulse_start1();
    check("start_in_done_busy",  64'(busy1), 64'd0);
    check("start_in_done_state", 64'(st1),   64'(S_IDLE));
    repeat (20) @(negedge clk);
    check("restart_done_count", 64'(done1_cnt - d0), 64'd1);

    // Reset mid-sweep: everything back to zero, no done, then a clean sweep.
    d0 = done1_cnt;
    fault1 = 2;
    exp1_q.push_back(mk_exp(1'b0, 8'd255, 8'h01, 8'h00, 16'd258));
    pulse_start1();
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    exp1_q.delete();
    @(negedge clk);
    check("midrst_busy", 64'(busy1), 64'd0);
    check("midrst_err",  64'(err1),  64'd0);
    check("midrst_fvec", 64'(fvec1), 64'd0);
    check("midrst_ab",   64'({a1, b1}), 64'd0);
    check("midrst_pass", 64'(pass1), 64'd0);
    rst_n = 1'b1;
    fault1 = 0;
    repeat (5) @(negedge clk);
    check("midrst_no_done", 64'(done1_cnt - d0), 64'd0);
    run1("post_rst", mk_exp(1'b1, 8'd0, 8'h00, 8'h00, 16'd258));

    // Three-stage adder: four drain cycles; 15+15 must be compared as 0x1E.
    fault3 = 0;
    run3("lat3_golden", mk_exp(1'b1, 8'd0, 8'h00, 8'h00, 16'd260));
    fault3 = 3;
    run3("lat3_last", mk_exp(1'b0, 8'd1, 8'hFF, 8'h0E, 16'd260));
    check("lat3_done_count", 64'(done3_cnt), 64'd2);

    check("queue1_empty", 64'(exp1_q.size()), 64'd0);
    check("queue3_empty", 64'(exp3_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
